// File: rtl/ifu.sv
// ifu - instruction fetch unit.
// Takes one-word read requests from the fetch stage and runs them as
// OCP-style reads on the instruction bus. Returns the fetched word and
// reports misalignment and bus error/timeout.
// Ports:
//   clk, nrst            clock, async active-low reset
//   i_addr, i_rd_cmd     fetch request (i_rd_cmd is a one-cycle strobe)
//   o_instr_dat          last fetched word (0 after any error)
//   o_busy               fetch stall, combinational
//   o_err_align          last request was not word aligned
//   o_err_bus            last request got ERR or timed out
//   o_MAddr/o_MCmd/o_MByteEn   bus command side
//   i_SCmdAccept/i_SData/i_SResp  bus slave side
module ifu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256,
  parameter int TCNT_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd_cmd,
  output logic [DATA_WIDTH-1:0] o_instr_dat,
  output logic                  o_busy,
  output logic                  o_err_align,
  output logic                  o_err_bus,
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]            o_MCmd,
  output logic [3:0]            o_MByteEn,
  input  logic                  i_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]            i_SResp
);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_READ = 3'b010;
  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;

  state_t                state, state_nxt;
  logic [TCNT_WIDTH-1:0] tcnt, tcnt_nxt;
  logic [DATA_WIDTH-1:0] instr_nxt;
  logic                  err_align_nxt, err_bus_nxt;
  logic [ADDR_WIDTH-1:0] maddr_nxt;
  logic [2:0]            mcmd_nxt;
  logic [3:0]            mbyteen_nxt;
  logic                  aligned, tmo_hit;

  assign aligned = (i_addr[1:0] == 2'b00);
  // Last NULL cycle allowed: counter starts at 0 in the first RESP cycle.
  assign tmo_hit = (TIMEOUT != 0) && (tcnt == TCNT_WIDTH'(TIMEOUT - 1));
  // Stall must assert in the request cycle itself, before any state change.
  assign o_busy  = (state != IDLE) || i_rd_cmd;

  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_rd_cmd && aligned) state_nxt = CMD;
      CMD:     if (i_SCmdAccept) state_nxt = RESP;
      RESP:    if (i_SResp != SRESP_NULL || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    instr_nxt     = o_instr_dat;
    err_align_nxt = o_err_align;
    err_bus_nxt   = o_err_bus;
    maddr_nxt     = o_MAddr;
    mcmd_nxt      = o_MCmd;
    mbyteen_nxt   = o_MByteEn;
    tcnt_nxt      = tcnt;
    case (state)
      IDLE: if (i_rd_cmd) begin
        err_align_nxt = 1'b0;
        err_bus_nxt   = 1'b0;
        if (!aligned) begin
          err_align_nxt = 1'b1;
          instr_nxt     = '0;   // NOP
        end else begin
          maddr_nxt   = i_addr;
          mcmd_nxt    = MCMD_READ;
          mbyteen_nxt = 4'hF;
        end
      end
      CMD: if (i_SCmdAccept) begin
        mcmd_nxt    = MCMD_IDLE;
        mbyteen_nxt = 4'h0;
        tcnt_nxt    = '0;
      end
      RESP: begin
        if (i_SResp == SRESP_DVA) begin
          instr_nxt = i_SData;
        end else if (i_SResp != SRESP_NULL || tmo_hit) begin
          // ERR, reserved code 10, or timeout
          err_bus_nxt = 1'b1;
          instr_nxt   = '0;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_instr_dat <= '0;
      o_err_align <= 1'b0;
      o_err_bus   <= 1'b0;
      o_MAddr     <= '0;
      o_MCmd      <= MCMD_IDLE;
      o_MByteEn   <= 4'h0;
      tcnt        <= '0;
    end else begin
      o_instr_dat <= instr_nxt;
      o_err_align <= err_align_nxt;
      o_err_bus   <= err_bus_nxt;
      o_MAddr     <= maddr_nxt;
      o_MCmd      <= mcmd_nxt;
      o_MByteEn   <= mbyteen_nxt;
      tcnt        <= tcnt_nxt;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: table of fetch transactions driven through a small bus
// slave sequence, expected results queued at request time and compared
// on completion, plus hand sequences for late response and reset mid-op.
module tb_ifu;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] i_addr;
  logic        i_rd_cmd;
  logic [31:0] o_instr_dat;
  logic        o_busy, o_err_align, o_err_bus;
  logic [31:0] o_MAddr;
  logic [2:0]  o_MCmd;
  logic [3:0]  o_MByteEn;
  logic        i_SCmdAccept;
  logic [31:0] i_SData;
  logic [1:0]  i_SResp;

  ifu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO), .TCNT_WIDTH(9)) dut (
    .clk(clk), .nrst(nrst), .i_addr(i_addr), .i_rd_cmd(i_rd_cmd),
    .o_instr_dat(o_instr_dat), .o_busy(o_busy), .o_err_align(o_err_align),
    .o_err_bus(o_err_bus), .o_MAddr(o_MAddr), .o_MCmd(o_MCmd),
    .o_MByteEn(o_MByteEn), .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData),
    .i_SResp(i_SResp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          acc;     // cycles of accept backpressure
    int          rdly;    // NULL cycles before the response
    logic [1:0]  resp;    // 00 means never respond (timeout)
    logic [31:0] data;
    logic        early;   // junk ERR in the accept cycle, must be ignored
    logic [31:0] e_instr;
    logic        e_align;
    logic        e_bus;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        align;
    logic        bus;
  } exp_t;

  vec_t vt[10];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [31:0] a, int acc, int rdly, logic [1:0] r,
                              logic [31:0] d, logic early, logic [31:0] ei,
                              logic ea, logic eb);
    vec_t v;
    v.addr = a; v.acc = acc; v.rdly = rdly; v.resp = r; v.data = d;
    v.early = early; v.e_instr = ei; v.e_align = ea; v.e_bus = eb;
    return v;
  endfunction

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_instr"}, o_instr_dat, e.instr);
    chk({nm, "_align"}, {31'd0, o_err_align}, {31'd0, e.align});
    chk({nm, "_bus"},   {31'd0, o_err_bus},   {31'd0, e.bus});
  endtask

  // Called at a negedge in an idle cycle; returns at the negedge of the
  // first idle cycle after completion, so calls chain back-to-back.
  task automatic run(input vec_t v, input string nm);
    exp_t e;
    int   cnt, exp_cnt;
    logic done;
    i_addr = v.addr; i_rd_cmd = 1'b1;
    #1 chk({nm, "_busy0"}, {31'd0, o_busy}, 32'd1);
    e.instr = v.e_instr; e.align = v.e_align; e.bus = v.e_bus;
    sb.push_back(e);
    @(negedge clk);
    i_rd_cmd = 1'b0;
    if (v.addr[1:0] != 2'b00) begin
      #1;
      chk({nm, "_mcmd_mis"}, {29'd0, o_MCmd}, 32'd0);
      chk({nm, "_busy_mis"}, {31'd0, o_busy}, 32'd0);
      pop_cmp(nm);
      return;
    end
    for (int k = 0; k <= v.acc; k++) begin
      if (k > 0) @(negedge clk);
      chk({nm, "_mcmd"},  {29'd0, o_MCmd}, 32'd2);
      chk({nm, "_maddr"}, o_MAddr, v.addr);
      chk({nm, "_ben"},   {28'd0, o_MByteEn}, 32'hF);
      chk({nm, "_busyc"}, {31'd0, o_busy}, 32'd1);
      chk({nm, "_errclr"}, {30'd0, o_err_align, o_err_bus}, 32'd0);
      i_SCmdAccept = (k == v.acc);
      i_SResp = (k == v.acc && v.early) ? 2'b11 : 2'b00;
      i_SData = 32'hBAD0_BAD0;
    end
    cnt = 0; done = 1'b0;
    exp_cnt = (v.resp != 2'b00) ? v.rdly + 1 : TMO;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) begin
        i_SCmdAccept = 1'b0;
        chk({nm, "_mcmd_acc"}, {29'd0, o_MCmd}, 32'd0);
        chk({nm, "_ben_acc"},  {28'd0, o_MByteEn}, 32'd0);
      end
      if (!o_busy) begin done = 1'b1; break; end
      i_SResp = (j == v.rdly) ? v.resp : 2'b00;
      i_SData = v.data;
      cnt++;
    end
    i_SResp = 2'b00;
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_resp_cycles"}, cnt, exp_cnt);
    chk({nm, "_maddr_hold"}, o_MAddr, v.addr);
    pop_cmp(nm);
  endtask

  initial begin
    vt[0] = mk(32'h0000_0100, 0, 0, 2'b01, 32'h2408_0005, 0, 32'h2408_0005, 0, 0);
    vt[1] = mk(32'h0000_0104, 4, 2, 2'b01, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0);
    vt[2] = mk(32'h0000_0102, 0, 0, 2'b01, 32'h0,         0, 32'h0,         1, 0);
    vt[3] = mk(32'h0000_0108, 1, 0, 2'b11, 32'h1111_1111, 0, 32'h0,         0, 1);
    vt[4] = mk(32'h0000_010C, 0, 1, 2'b01, 32'h1234_5678, 1, 32'h1234_5678, 0, 0);
    vt[5] = mk(32'h0000_0110, 0, 3, 2'b10, 32'h2222_2222, 0, 32'h0,         0, 1);
    vt[6] = mk(32'h0000_0003, 0, 0, 2'b01, 32'h0,         0, 32'h0,         1, 0);
    vt[7] = mk(32'h0000_0118, 2, 0, 2'b01, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0, 0);
    vt[8] = mk(32'h0000_0114, 2, 0, 2'b00, 32'h3333_3333, 0, 32'h0,         0, 1);
    vt[9] = mk(32'h0000_0200, 0, 0, 2'b01, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 0, 0);

    nrst = 1'b0; i_addr = '0; i_rd_cmd = 1'b0;
    i_SCmdAccept = 1'b0; i_SData = '0; i_SResp = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_instr", o_instr_dat, 32'd0);
    chk("rst_flags", {30'd0, o_err_align, o_err_bus}, 32'd0);
    chk("rst_maddr", o_MAddr, 32'd0);
    chk("rst_mcmd",  {29'd0, o_MCmd}, 32'd0);
    chk("rst_ben",   {28'd0, o_MByteEn}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run(vt[i], $sformatf("v%0d", i));

    // late DVA after timeout must not change anything
    i_SResp = 2'b01; i_SData = 32'h5555_5555;
    @(negedge clk);
    i_SResp = 2'b00;
    chk("late_instr", o_instr_dat, 32'd0);
    chk("late_bus",   {31'd0, o_err_bus}, 32'd1);
    chk("late_busy",  {31'd0, o_busy}, 32'd0);
    chk("late_mcmd",  {29'd0, o_MCmd}, 32'd0);

    // reset while the command is waiting for accept
    i_addr = 32'h0000_0200; i_rd_cmd = 1'b1;
    @(negedge clk);
    i_rd_cmd = 1'b0;
    chk("mid_mcmd_pre", {29'd0, o_MCmd}, 32'd2);
    nrst = 1'b0;
    i_SResp = 2'b01; i_SData = 32'h7777_7777;
    #1;
    chk("mid_mcmd", {29'd0, o_MCmd}, 32'd0);
    chk("mid_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    i_SResp = 2'b00;
    chk("mid_instr", o_instr_dat, 32'd0);
    chk("mid_busy2", {31'd0, o_busy}, 32'd0);
    run(vt[9], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
